// File: rtl/cnn_frame_scheduler.sv
// Round-robin job scheduler in front of the CNN frame controller: arbitrates, latches config, counts beats, drains.
// Optional CNN_SCHED_PERF_EN adds o_job_cycles (start-to-done cycle count of the last successful job).
module cnn_frame_scheduler #(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned W_SIZE       = 12,
    parameter int unsigned W_FRAME_SIZE = 25,
    parameter int unsigned W_DELAY      = 12,
    parameter int unsigned DRAIN_MAX    = 1023
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          i_req,
    input  logic [N_REQ*W_SIZE-1:0]   i_cfg_width,
    input  logic [N_REQ*W_SIZE-1:0]   i_cfg_height,
    input  logic [N_REQ-1:0]          i_cfg_is_conv3x3,
    input  logic [W_DELAY-1:0]        i_start_up_delay,
    input  logic [W_DELAY-1:0]        i_hsync_delay,
    input  logic                      i_ctrl_vsync_run,
    input  logic                      i_ctrl_hsync_run,
    input  logic                      i_ctrl_data_run,
    output logic                      o_q_start,
    output logic                      o_q_is_conv3x3,
    output logic [W_SIZE-1:0]         o_q_width,
    output logic [W_SIZE-1:0]         o_q_height,
    output logic [W_FRAME_SIZE-1:0]   o_q_frame_size,
    output logic [W_DELAY-1:0]        o_q_start_up_delay,
    output logic [W_DELAY-1:0]        o_q_hsync_delay,
    output logic [N_REQ-1:0]          o_grant,
    output logic                      o_done,
    output logic [2:0]                o_done_id,
    output logic                      o_err,
    output logic                      o_busy
`ifdef CNN_SCHED_PERF_EN
    ,
    output logic [31:0]               o_job_cycles
`endif
);

    localparam int unsigned W_BEAT  = W_FRAME_SIZE + 4;
    localparam int unsigned W_DRAIN = (DRAIN_MAX < 2) ? 1 : $clog2(DRAIN_MAX);

    typedef enum logic [1:0] {IDLE, LAUNCH, RUN, DRAIN} state_t;

    state_t              state, state_next;
    logic [2:0]          ptr;
    logic [2:0]          own_idx;
    logic [W_BEAT-1:0]   beat_cnt;
    logic [W_DRAIN-1:0]  drain_cnt;

    logic                win_valid;
    logic [2:0]          win_idx;
    logic [W_SIZE-1:0]   win_width;
    logic [W_SIZE-1:0]   win_height;
    logic                win_conv;
    int unsigned         arb_idx;

    logic [W_BEAT-1:0]   frame_ext;
    logic [W_BEAT-1:0]   job_beats;
    logic                launch_zero;
    logic                last_beat;
    logic                drain_idle;
    logic                drain_timeout;

    assign o_busy    = (state != IDLE);
    assign frame_ext = W_BEAT'(o_q_frame_size);
    assign job_beats = o_q_is_conv3x3 ? (frame_ext << 3) + frame_ext : frame_ext;

    // First requesting index at or above the pointer, wrapping modulo N_REQ.
    always_comb begin
        win_valid  = 1'b0;
        win_idx    = '0;
        win_width  = '0;
        win_height = '0;
        win_conv   = 1'b0;
        arb_idx    = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            arb_idx = (32'(ptr) + i) % N_REQ;
            if (!win_valid && i_req[arb_idx]) begin
                win_valid  = 1'b1;
                win_idx    = 3'(arb_idx);
                win_width  = i_cfg_width[arb_idx*W_SIZE +: W_SIZE];
                win_height = i_cfg_height[arb_idx*W_SIZE +: W_SIZE];
                win_conv   = i_cfg_is_conv3x3[arb_idx];
            end
        end
    end

    always_comb begin
        state_next    = state;
        launch_zero   = 1'b0;
        last_beat     = 1'b0;
        drain_idle    = 1'b0;
        drain_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (win_valid) state_next = LAUNCH;
            end
            LAUNCH: begin
                launch_zero = (o_q_width == '0) || (o_q_height == '0);
                state_next  = launch_zero ? IDLE : RUN;
            end
            RUN: begin
                last_beat = i_ctrl_data_run && (beat_cnt == job_beats - W_BEAT'(1));
                if (last_beat) state_next = DRAIN;
            end
            DRAIN: begin
                drain_idle    = !(i_ctrl_vsync_run || i_ctrl_hsync_run || i_ctrl_data_run);
                drain_timeout = !drain_idle && (drain_cnt == W_DRAIN'(DRAIN_MAX - 1));
                if (drain_idle || drain_timeout) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr                <= '0;
            own_idx            <= '0;
            beat_cnt           <= '0;
            drain_cnt          <= '0;
            o_q_start          <= 1'b0;
            o_q_is_conv3x3     <= 1'b0;
            o_q_width          <= '0;
            o_q_height         <= '0;
            o_q_frame_size     <= '0;
            o_q_start_up_delay <= '0;
            o_q_hsync_delay    <= '0;
            o_grant            <= '0;
            o_done             <= 1'b0;
            o_done_id          <= '0;
            o_err              <= 1'b0;
        end else begin
            o_q_start <= 1'b0;
            o_done    <= 1'b0;
            o_err     <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        o_grant            <= N_REQ'(1) << win_idx;
                        own_idx            <= win_idx;
                        ptr                <= (32'(win_idx) == N_REQ - 1) ? '0 : win_idx + 3'd1;
                        o_q_width          <= win_width;
                        o_q_height         <= win_height;
                        o_q_is_conv3x3     <= win_conv;
                        o_q_frame_size     <= W_FRAME_SIZE'(win_width) * W_FRAME_SIZE'(win_height);
                        o_q_start_up_delay <= i_start_up_delay;
                        o_q_hsync_delay    <= i_hsync_delay;
                        beat_cnt           <= '0;
                    end
                end
                LAUNCH: begin
                    if (launch_zero) begin
                        o_done    <= 1'b1;
                        o_err     <= 1'b1;
                        o_done_id <= own_idx;
                        o_grant   <= '0;
                    end else begin
                        o_q_start <= 1'b1;
                    end
                end
                RUN: begin
                    if (last_beat) begin
                        o_done    <= 1'b1;
                        o_done_id <= own_idx;
                        beat_cnt  <= '0;
                        drain_cnt <= '0;
                    end else if (i_ctrl_data_run) begin
                        beat_cnt <= beat_cnt + W_BEAT'(1);
                    end
                end
                DRAIN: begin
                    if (drain_idle) begin
                        o_grant <= '0;
                    end else if (drain_timeout) begin
                        o_err     <= 1'b1;
                        o_done_id <= own_idx;
                        o_grant   <= '0;
                    end else begin
                        drain_cnt <= drain_cnt + W_DRAIN'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CNN_SCHED_PERF_EN
    logic [31:0] perf_cnt;
    logic [31:0] perf_inc;

    assign perf_inc = (perf_cnt == '1) ? '1 : perf_cnt + 32'd1;

    // perf_cnt is 0 in the o_q_start cycle, so perf_inc on the last beat equals start-to-done distance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cnt     <= '0;
            o_job_cycles <= '0;
        end else if (state == LAUNCH) begin
            perf_cnt <= '0;
        end else if (state == RUN) begin
            perf_cnt <= perf_inc;
            if (last_beat) o_job_cycles <= perf_inc;
        end
    end
`endif

endmodule

// File: tb/tb_cnn_frame_scheduler.sv
// Self-checking bench for cnn_frame_scheduler: table-driven single jobs plus round-robin, zero-size, timeout and reset sequences.
module tb_cnn_frame_scheduler;

    localparam int N  = 4;
    localparam int WS = 12;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*WS-1:0] cfg_w = '0;
    logic [N*WS-1:0] cfg_h = '0;
    logic [N-1:0]    cfg_conv = '0;
    logic [11:0]     sud = '0;
    logic [11:0]     hsd = '0;
    logic            vsync = 1'b0;
    logic            hsync = 1'b0;
    logic            data = 1'b0;

    logic            q_start, q_conv, done, err, busy;
    logic [WS-1:0]   q_width, q_height;
    logic [24:0]     q_frame;
    logic [11:0]     q_sud, q_hsd;
    logic [N-1:0]    grant;
    logic [2:0]      done_id;

    always #5 clk = ~clk;

    cnn_frame_scheduler #(.N_REQ(N), .DRAIN_MAX(15)) dut (
        .clk(clk), .rst(rst), .i_req(req),
        .i_cfg_width(cfg_w), .i_cfg_height(cfg_h), .i_cfg_is_conv3x3(cfg_conv),
        .i_start_up_delay(sud), .i_hsync_delay(hsd),
        .i_ctrl_vsync_run(vsync), .i_ctrl_hsync_run(hsync), .i_ctrl_data_run(data),
        .o_q_start(q_start), .o_q_is_conv3x3(q_conv), .o_q_width(q_width),
        .o_q_height(q_height), .o_q_frame_size(q_frame),
        .o_q_start_up_delay(q_sud), .o_q_hsync_delay(q_hsd),
        .o_grant(grant), .o_done(done), .o_done_id(done_id), .o_err(err), .o_busy(busy)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [2:0] id;
        logic       done;
        logic       err;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    typedef struct {
        int   req;
        int   w;
        int   h;
        logic conv;
        int   frame;
        int   beats;
        int   hold;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Completion/error pulses are matched in order against the expectations queued by the stimulus.
    always @(negedge clk) begin
        if (!rst && (done || err)) begin
            check("sb_nonempty", 64'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("done_id", done_id, mon_e.id);
                check("done_flag", done, mon_e.done);
                check("err_flag", err, mon_e.err);
            end
        end
    end

    task automatic set_cfg(input int k, input int w, input int h, input logic conv);
        cfg_w[k*WS +: WS] = WS'(w);
        cfg_h[k*WS +: WS] = WS'(h);
        cfg_conv[k]       = conv;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        vsync = 1'b0;
        hsync = 1'b0;
        data = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_job(input vec_t v);
        logic [N-1:0] oh;
        int early;
        oh = 4'b0001 << v.req;
        set_cfg(v.req, v.w, v.h, v.conv);
        sud = 12'h100 + 12'(v.req);
        hsd = 12'h020 + 12'(v.req);
        req = oh;
        @(negedge clk);
        check("grant", grant, oh);
        check("start_not_yet", q_start, 0);
        req = '0;
        @(negedge clk);
        check("start", q_start, 1);
        check("frame_size", q_frame, v.frame);
        check("q_conv", q_conv, v.conv);
        check("q_delays", {q_sud, q_hsd}, {12'h100 + 12'(v.req), 12'h020 + 12'(v.req)});
        data = 1'b1;
        early = 0;
        for (int b = 1; b <= v.beats; b++) begin
            if (b == v.beats) sb.push_back('{id: 3'(v.req), done: 1'b1, err: 1'b0});
            @(negedge clk);
            if (b == 1) check("start_pulse_len", q_start, 0);
            if (b < v.beats && done) early++;
        end
        check("no_early_done", early, 0);
        check("done_on_last_beat", done, 1);
        data = 1'b0;
        hsync = (v.hold != 0);
        for (int h = 0; h < v.hold; h++) @(negedge clk);
        if (v.hold > 0) check("grant_held_in_drain", grant, oh);
        hsync = 1'b0;
        @(negedge clk);
        check("grant_cleared", grant, 0);
        check("idle_after_drain", busy, 0);
    endtask

    task automatic round_robin();
        logic [N-1:0] oh;
        int n;
        do_reset();
        for (int k = 0; k < N; k++) set_cfg(k, 1, 1, 1'b0);
        req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            n = 0;
            while (grant == '0 && n < 10) begin
                @(negedge clk);
                n++;
            end
            oh = 4'b0001 << (j % N);
            check("rr_grant", grant, oh);
            @(negedge clk);
            check("rr_start", q_start, 1);
            data = 1'b1;
            sb.push_back('{id: 3'(j % N), done: 1'b1, err: 1'b0});
            @(negedge clk);
            check("rr_done", done, 1);
            data = 1'b0;
            @(negedge clk);
            check("rr_release", grant, 0);
        end
        req = '0;
        @(negedge clk);
    endtask

    task automatic zero_size();
        do_reset();
        set_cfg(2, 0, 3, 1'b0);
        set_cfg(3, 1, 1, 1'b0);
        req = 4'b1100;
        @(negedge clk);
        check("zero_grant", grant, 4'b0100);
        sb.push_back('{id: 3'd2, done: 1'b1, err: 1'b1});
        @(negedge clk);
        check("zero_no_start", q_start, 0);
        check("zero_done", {done, err}, 2'b11);
        check("zero_grant_clear", grant, 0);
        req = 4'b1000;
        @(negedge clk);
        check("zero_next_grant", grant, 4'b1000);
        req = '0;
        @(negedge clk);
        check("zero_next_start", q_start, 1);
        data = 1'b1;
        sb.push_back('{id: 3'd3, done: 1'b1, err: 1'b0});
        @(negedge clk);
        check("zero_next_done", done, 1);
        data = 1'b0;
        @(negedge clk);
        check("zero_next_release", grant, 0);
    endtask

    task automatic drain_timeout();
        int n;
        do_reset();
        set_cfg(0, 1, 1, 1'b0);
        req = 4'b0001;
        @(negedge clk);
        req = '0;
        @(negedge clk);
        check("to_start", q_start, 1);
        data = 1'b1;
        sb.push_back('{id: 3'd0, done: 1'b1, err: 1'b0});
        @(negedge clk);
        check("to_done", done, 1);
        sb.push_back('{id: 3'd0, done: 1'b0, err: 1'b1});
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!err && n < 30);
        check("drain_timeout_cycles", n, 15);
        check("timeout_no_done", done, 0);
        check("timeout_idle", busy, 0);
        check("timeout_grant_clear", grant, 0);
        data = 1'b0;
        @(negedge clk);
    endtask

    task automatic reset_mid_run();
        do_reset();
        set_cfg(1, 3, 3, 1'b0);
        req = 4'b0010;
        @(negedge clk);
        req = '0;
        @(negedge clk);
        data = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_async_outputs", {grant, q_start, done, err, busy, q_conv, q_width, q_height, q_frame},
              '0);
        @(negedge clk);
        data = 1'b0;
        rst = 1'b0;
        set_cfg(1, 1, 1, 1'b0);
        set_cfg(3, 1, 1, 1'b0);
        req = 4'b1010;
        @(negedge clk);
        check("rst_ptr_zero", grant, 4'b0010);
        req = '0;
        @(negedge clk);
        check("rst_fresh_start", q_start, 1);
        data = 1'b1;
        sb.push_back('{id: 3'd1, done: 1'b1, err: 1'b0});
        @(negedge clk);
        check("rst_fresh_done", done, 1);
        data = 1'b0;
        @(negedge clk);
        check("rst_fresh_release", grant, 0);
    endtask

    vec_t vecs[4];

    initial begin
        vecs[0] = '{req: 0, w: 4, h: 2, conv: 1'b0, frame: 8,  beats: 8,  hold: 0};
        vecs[1] = '{req: 1, w: 2, h: 2, conv: 1'b1, frame: 4,  beats: 36, hold: 2};
        vecs[2] = '{req: 3, w: 3, h: 5, conv: 1'b0, frame: 15, beats: 15, hold: 1};
        vecs[3] = '{req: 2, w: 1, h: 1, conv: 1'b1, frame: 1,  beats: 9,  hold: 0};

        @(negedge clk);
        check("reset_grant", grant, 0);
        check("reset_pulses", {q_start, done, err, busy}, 4'b0000);
        check("reset_cfg", {q_conv, q_width, q_height, q_frame, q_sud, q_hsd}, '0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) run_job(vecs[i]);
        round_robin();
        zero_size();
        drain_timeout();
        reset_mid_run();

        @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cnn_frame_scheduler.md
Name: cnn_frame_scheduler

Overview:
- Round-robin scheduler that shares one CNN frame-sequencing datapath (vsync/hsync/data controller plus conv3x3 engine) among N_REQ job requesters.
- Latches the winning requester's frame configuration and issues a one-cycle start.
- Counts data beats to detect job completion, drains the datapath, then grants the next requester.
- Sits between the AHB-side job registers and the frame controller.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- W_SIZE, 12, width/height field width.
- W_FRAME_SIZE, 25, frame-size width (2*W_SIZE+1).
- W_DELAY, 12, start-up/hsync delay width.
- DRAIN_MAX, 1023, max DRAIN cycles before timeout.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- i_req  in  N_REQ  per-requester job request, level; hold until own o_done
- i_cfg_width  in  N_REQ*W_SIZE  packed widths; requester k at [k*W_SIZE +: W_SIZE]
- i_cfg_height  in  N_REQ*W_SIZE  packed heights
- i_cfg_is_conv3x3  in  N_REQ  per-requester conv3x3 mode
- i_start_up_delay  in  W_DELAY  shared vsync delay
- i_hsync_delay  in  W_DELAY  shared hsync delay
- i_ctrl_vsync_run  in  1  datapath in VSYNC
- i_ctrl_hsync_run  in  1  datapath in HSYNC
- i_ctrl_data_run  in  1  datapath in DATA; one beat per high cycle
- o_q_start  out  1  one-cycle start pulse to datapath
- o_q_is_conv3x3  out  1  latched mode
- o_q_width  out  W_SIZE  latched width
- o_q_height  out  W_SIZE  latched height
- o_q_frame_size  out  W_FRAME_SIZE  width*height, zero-extended
- o_q_start_up_delay  out  W_DELAY  latched
- o_q_hsync_delay  out  W_DELAY  latched
- o_grant  out  N_REQ  one-hot owner; zero when idle
- o_done  out  1  one-cycle completion pulse
- o_done_id  out  3  requester index for o_done; valid with o_done
- o_err  out  1  one-cycle pulse with o_done: zero-size job or drain timeout
- o_busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst=1): all outputs 0; state IDLE; round-robin pointer 0; counters 0.
- States: IDLE, LAUNCH, RUN, DRAIN.
- IDLE, arbitration:
  - Winner is the first requester with i_req=1 searching from pointer upward with wrap.
  - On a win at cycle t: at t+1 state=LAUNCH, o_grant=onehot(win), config latched, pointer=win+1 mod N_REQ.
  - Latched config: width, height, mode, both delays, frame_size=width*height.
- LAUNCH:
  - If width==0 or height==0: o_done=o_err=1, o_done_id=win, o_grant cleared, state→IDLE, no o_q_start.
  - Otherwise: o_q_start=1 for exactly this cycle, state→RUN.
  - Fixed latency: request to start = 2 cycles.
- RUN:
  - job_beats = frame_size, or 9*frame_size if conv3x3. Beat counter is W_FRAME_SIZE+4 bits; no overflow.
  - Counter increments on each i_ctrl_data_run cycle.
  - When data_run && count==job_beats-1: o_done=1, o_done_id=owner, counter cleared, state→DRAIN.
  - o_grant and all o_q_* held stable for the whole job.
  - Deassertion of the owner's i_req mid-job is ignored; the job completes.
- DRAIN:
  - Exits to IDLE (o_grant cleared) in the first cycle where vsync_run, hsync_run and data_run are all 0.
  - Otherwise, after DRAIN_MAX cycles: o_err pulse (o_done_id repeated, o_done stays 0), force IDLE.
  - Drain counter is cleared on entry.
- IDLE re-arbitration: new grant possible the cycle after entering IDLE; the previous owner has lowest priority.
- Simultaneous requests: strict round-robin; no requester is starved beyond N_REQ-1 jobs.
- Reset mid-job: immediate return to the reset state; o_q_start is never glitched.

Optional Feature:
- CNN_SCHED_PERF_EN defined:
  - Adds output o_job_cycles (32 bits): cycles from o_q_start to o_done of the last successful job.
  - Updated together with o_done; reset 0; saturates at all-ones.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Single job: req[0]=1, width=4, height=2, normal → o_q_start 2 cycles later, o_q_frame_size=8; o_done with id=0 after 8th data_run beat; grant clears when run signals drop.
- Conv3x3: req[1]=1, width=2, height=2, conv=1 → o_done after exactly 36 data_run beats.
- Round robin: req=4'b1111 held → grant order 0,1,2,3,0; pointer wraps correctly.
- Zero size: req[2], width=0 → o_done=o_err=1, id=2, no o_q_start; next requester granted.
- Drain timeout: DRAIN_MAX=15, hold data_run=1 after completion → o_err pulse 15 cycles after DRAIN entry; state IDLE.
- Reset mid-RUN: assert rst during beat 3 → all outputs 0 asynchronously; after release, pointer=0 and a fresh arbitration occurs.
